// File: rtl/sfft_reader_pkg.sv
// Shared types and address helpers for the SFFT snapshot reader.
package sfft_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOCK,
        RD_TIME,
        RD_VALID,
        RD_BIN,
        EMIT,
        UNLOCK,
        DONE
    } state_t;

    localparam logic [7:0] LOCK_VAL   = 8'h01;
    localparam logic [7:0] UNLOCK_VAL = 8'h00;

    // The timestamp and valid byte sit just past the bin region.
    function automatic logic [15:0] time_byte_base(input int nfft);
        return 16'(nfft * 2);
    endfunction

    function automatic logic [15:0] valid_byte_addr(input int nfft);
        return 16'(nfft * 2 + 4);
    endfunction

endpackage

// File: rtl/sfft_snapshot_reader_if.sv
// Byte bus to the SFFT accelerator plus the outgoing 32-bit bin word stream.
interface sfft_snapshot_reader_if #(
    parameter int NFFT = 512
);
    localparam int KW = $clog2(NFFT / 2);

    logic            chipselect;
    logic            write;
    logic [7:0]      writedata;
    logic [15:0]     address;
    logic [7:0]      readdata;
    logic [31:0]     word_data;
    logic [KW-1:0]   word_index;
    logic            word_valid;
    logic            word_ready;

    modport master (
        output chipselect, write, writedata, address,
        output word_data, word_index, word_valid,
        input  readdata, word_ready
    );

    modport slave (
        input  chipselect, write, writedata, address,
        input  word_data, word_index, word_valid,
        output readdata, word_ready
    );

endinterface

// File: rtl/byte_word_assembler.sv
// Paces byte reads by READ_LATENCY and shifts bytes little-endian into a 32-bit word.
module byte_word_assembler #(
    parameter int READ_LATENCY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        single,
    input  logic [7:0]  readdata,
    output logic [1:0]  byte_idx,
    output logic        word_done,
    output logic [31:0] word_next
);

    localparam int LAT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY);

    logic [LAT_W-1:0] lat_cnt;
    logic [23:0]      word_q;
    logic             capture;

    assign capture   = run && (lat_cnt == '0);
    assign word_done = capture && (single || (byte_idx == 2'd3));
    // Newest byte enters at the top so byte 0 ends up in bits [7:0].
    assign word_next = {readdata, word_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt  <= LAT_LOAD;
            byte_idx <= '0;
            word_q   <= '0;
        end else if (!run) begin
            lat_cnt  <= LAT_LOAD;
            byte_idx <= '0;
        end else if (capture) begin
            lat_cnt  <= LAT_LOAD;
            byte_idx <= word_done ? 2'd0 : byte_idx + 2'd1;
            word_q   <= word_next[31:8];
        end else begin
            lat_cnt  <= lat_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/sfft_snapshot_reader.sv
// Bus master that locks the SFFT accelerator, reads timestamp/valid/bins, streams bin words, unlocks.
// IDLE wait start | LOCK write 01 | RD_TIME 4 time bytes | RD_VALID valid byte
// RD_BIN 4 bin bytes | EMIT offer word | UNLOCK write 00 | DONE done pulse
module sfft_snapshot_reader
    import sfft_reader_pkg::*;
#(
    parameter int          NFFT         = 512,
    parameter int          READ_LATENCY = 0,
    parameter logic [15:0] CTRL_ADDR    = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    sfft_snapshot_reader_if.master bus,
    output logic [31:0]            frame_time,
    output logic                   frame_error
);

    localparam int KW = $clog2(NFFT / 2);
    localparam logic [KW-1:0] K_LAST = KW'(NFFT / 2 - 1);

    state_t         state, state_nxt;
    logic [KW-1:0]  k;
    logic [31:0]    word_data;
    logic [1:0]     byte_idx;
    logic           word_done;
    logic [31:0]    word_next;
    logic           run, single;
    logic           cs, wr;
    logic [7:0]     wdata;
    logic [15:0]    addr;

    byte_word_assembler #(
        .READ_LATENCY (READ_LATENCY)
    ) u_asm (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .single    (single),
        .readdata  (bus.readdata),
        .byte_idx  (byte_idx),
        .word_done (word_done),
        .word_next (word_next)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cs        = 1'b0;
        wr        = 1'b0;
        wdata     = 8'h00;
        addr      = 16'h0000;
        run       = 1'b0;
        single    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOCK;
            end
            LOCK: begin
                cs        = 1'b1;
                wr        = 1'b1;
                wdata     = LOCK_VAL;
                addr      = CTRL_ADDR;
                state_nxt = RD_TIME;
            end
            RD_TIME: begin
                cs   = 1'b1;
                run  = 1'b1;
                addr = time_byte_base(NFFT) + {14'd0, byte_idx};
                if (word_done) state_nxt = RD_VALID;
            end
            RD_VALID: begin
                cs     = 1'b1;
                run    = 1'b1;
                single = 1'b1;
                addr   = valid_byte_addr(NFFT);
                if (word_done) state_nxt = bus.readdata[0] ? RD_BIN : UNLOCK;
            end
            RD_BIN: begin
                cs   = 1'b1;
                run  = 1'b1;
                addr = 16'({k, byte_idx});
                if (word_done) state_nxt = EMIT;
            end
            EMIT: begin
                // Bus stays idle while the consumer stalls; the lock keeps the frame coherent.
                if (bus.word_ready) state_nxt = (k == K_LAST) ? UNLOCK : RD_BIN;
            end
            UNLOCK: begin
                cs        = 1'b1;
                wr        = 1'b1;
                wdata     = UNLOCK_VAL;
                addr      = CTRL_ADDR;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k           <= '0;
            word_data   <= '0;
            frame_time  <= '0;
            frame_error <= 1'b0;
        end else begin
            case (state)
                LOCK:     k <= '0;
                RD_TIME:  if (word_done) frame_time <= word_next;
                RD_VALID: if (word_done) frame_error <= ~bus.readdata[0];
                RD_BIN:   if (word_done) word_data <= word_next;
                EMIT:     if (bus.word_ready && (k != K_LAST)) k <= k + 1'b1;
                default:  ;
            endcase
        end
    end

    assign bus.chipselect = cs;
    assign bus.write      = wr;
    assign bus.writedata  = wdata;
    assign bus.address    = addr;
    assign bus.word_valid = (state == EMIT);
    assign bus.word_data  = word_data;
    assign bus.word_index = k;
    assign busy           = (state != IDLE) && (state != DONE);
    assign done           = (state == DONE);

endmodule

// File: tb/tb_sfft_snapshot_reader.sv
// Scoreboard bench for sfft_snapshot_reader: NFFT=16 with a combinational and a registered slave.
module tb_sfft_snapshot_reader;

    logic        clk = 1'b0;
    logic        rst0, rst1, start0, start1, ready0;
    logic        busy0, done0, ferr0, busy1, done1, ferr1;
    logic [31:0] ftime0, ftime1;
    logic [7:0]  valid0, valid1;
    logic [31:0] time0, time1, exp_time0;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cyc0, rd_cyc1, words0, words1, done_cnt0;
    logic [34:0] exp_q0[$];
    logic [34:0] exp_q1[$];
    logic [23:0] wr_log0[$];
    logic [34:0] e0, e1, held0;
    bit          hold0;

    always #5 clk = ~clk;

    sfft_snapshot_reader_if #(.NFFT(16)) b0 ();
    sfft_snapshot_reader_if #(.NFFT(16)) b1 ();

    sfft_snapshot_reader #(.NFFT(16), .READ_LATENCY(0), .CTRL_ADDR(16'h0000)) dut0 (
        .clk(clk), .reset(rst0), .start(start0), .busy(busy0), .done(done0),
        .bus(b0), .frame_time(ftime0), .frame_error(ferr0)
    );

    sfft_snapshot_reader #(.NFFT(16), .READ_LATENCY(1), .CTRL_ADDR(16'h0000)) dut1 (
        .clk(clk), .reset(rst1), .start(start1), .busy(busy1), .done(done1),
        .bus(b1), .frame_time(ftime1), .frame_error(ferr1)
    );

    function automatic logic [7:0] slave_byte(input logic [15:0] a, input logic [7:0] vb,
                                              input logic [31:0] t);
        logic [7:0] r;
        r = a[7:0];
        case (a)
            16'd32: r = t[7:0];
            16'd33: r = t[15:8];
            16'd34: r = t[23:16];
            16'd35: r = t[31:24];
            16'd36: r = vb;
            default: ;
        endcase
        return r;
    endfunction

    assign b0.readdata   = slave_byte(b0.address, valid0, time0);
    assign b0.word_ready = ready0;
    assign b1.word_ready = 1'b1;
    always @(posedge clk) b1.readdata <= slave_byte(b1.address, valid1, time1);

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // dut0 monitor: bus log, stall stability and word scoreboard
    initial forever begin
        @(negedge clk);
        if (rst0) begin
            hold0 = 1'b0;
        end else begin
            if (b0.chipselect) begin
                if (b0.write) wr_log0.push_back({b0.writedata, b0.address});
                else          rd_cyc0++;
            end
            if (done0) done_cnt0++;
            if (b0.word_valid) begin
                n_checks++;
                if (b0.chipselect !== 1'b0) begin
                    n_fail++;
                    $display("FAIL emit_chipselect: got %b want 0", b0.chipselect);
                end
                if (hold0) begin
                    n_checks++;
                    if ({b0.word_index, b0.word_data} !== held0) begin
                        n_fail++;
                        $display("FAIL stall_hold: got %h want %h", {b0.word_index, b0.word_data}, held0);
                    end
                end
                if (ready0) begin
                    hold0 = 1'b0;
                    words0++;
                    n_checks++;
                    if (exp_q0.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_word0: got idx %0d data %h want none",
                                 b0.word_index, b0.word_data);
                    end else begin
                        e0 = exp_q0.pop_front();
                        if ({b0.word_index, b0.word_data} !== e0) begin
                            n_fail++;
                            $display("FAIL word0: got %h want %h", {b0.word_index, b0.word_data}, e0);
                        end
                    end
                end else begin
                    hold0 = 1'b1;
                    held0 = {b0.word_index, b0.word_data};
                end
            end else begin
                hold0 = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst1) begin
            if (b1.chipselect && !b1.write) rd_cyc1++;
            if (b1.word_valid) begin
                words1++;
                n_checks++;
                if (exp_q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word1: got idx %0d data %h want none",
                             b1.word_index, b1.word_data);
                end else begin
                    e1 = exp_q1.pop_front();
                    if ({b1.word_index, b1.word_data} !== e1) begin
                        n_fail++;
                        $display("FAIL word1: got %h want %h", {b1.word_index, b1.word_data}, e1);
                    end
                end
            end
        end
    end

    task automatic push_words(input bit to_q1);
        for (int k = 0; k < 8; k++) begin
            if (to_q1) exp_q1.push_back({3'(k), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
            else       exp_q0.push_back({3'(k), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        end
    endtask

    task automatic frame0(input string name, input logic [7:0] vb, input logic [31:0] tval,
                          input bit do_stall, input int exp_cyc);
        int cyc, stall_n, d0, exp_rd, exp_words;
        valid0 = vb; time0 = tval;
        wr_log0.delete(); rd_cyc0 = 0; words0 = 0; d0 = done_cnt0; stall_n = 0;
        exp_rd    = vb[0] ? 37 : 5;
        exp_words = vb[0] ? 8 : 0;
        if (vb[0]) push_words(1'b0);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        cyc = 1;
        while (done0 !== 1'b1 && cyc < 500) begin
            if (cyc == 5) begin
                n_checks++;
                if (ftime0 !== exp_time0) begin
                    n_fail++;
                    $display("FAIL %s time_staged: got %h want %h", name, ftime0, exp_time0);
                end
            end
            if (cyc == 6) begin
                n_checks++;
                if (ftime0 !== tval) begin
                    n_fail++;
                    $display("FAIL %s time_updated: got %h want %h", name, ftime0, tval);
                end
            end
            start0 = (cyc == 10);
            if (do_stall && b0.word_valid && b0.word_index == 3'd3 && stall_n < 10) begin
                ready0 = 1'b0;
                stall_n++;
            end else begin
                ready0 = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start0 = 1'b0; ready0 = 1'b1;
        n_checks++;
        if (cyc !== exp_cyc) begin
            n_fail++;
            $display("FAIL %s frame_cycles: got %0d want %0d (done=%b)", name, cyc, exp_cyc, done0);
        end
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_at_done: got %b want 0", name, busy0);
        end
        n_checks++;
        if (ferr0 !== ~vb[0] || ftime0 !== tval) begin
            n_fail++;
            $display("FAIL %s status: got err %b time %h want err %b time %h",
                     name, ferr0, ftime0, ~vb[0], tval);
        end
        n_checks++;
        if (wr_log0.size() != 2 || wr_log0[0] !== 24'h01_0000 || wr_log0[1] !== 24'h00_0000) begin
            n_fail++;
            $display("FAIL %s lock_unlock: got %0d writes first %h last %h want 2 writes 010000/000000",
                     name, wr_log0.size(), wr_log0[0], wr_log0[$]);
        end
        n_checks++;
        if (rd_cyc0 !== exp_rd || words0 !== exp_words || exp_q0.size() != 0) begin
            n_fail++;
            $display("FAIL %s read_count: got reads %0d words %0d left %0d want reads %0d words %0d left 0",
                     name, rd_cyc0, words0, exp_q0.size(), exp_rd, exp_words);
        end
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || done_cnt0 !== d0 + 1) begin
            n_fail++;
            $display("FAIL %s after_done: got busy %b done %b pulses %0d want 0 0 1",
                     name, busy0, done0, done_cnt0 - d0);
        end
        exp_time0 = tval;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if ({busy0, done0, b0.chipselect, b0.write, b0.writedata, b0.address, b0.word_valid,
             b0.word_data, b0.word_index, ftime0, ferr0} !== '0) begin
            n_fail++;
            $display("FAIL reset_state0: got cs %b wr %b addr %h data %h time %h want all zero",
                     b0.chipselect, b0.write, b0.address, b0.word_data, ftime0);
        end
        n_checks++;
        if ({busy1, done1, b1.chipselect, b1.write, b1.writedata, b1.address, b1.word_valid,
             b1.word_data, b1.word_index, ftime1, ferr1} !== '0) begin
            n_fail++;
            $display("FAIL reset_state1: got cs %b wr %b addr %h data %h time %h want all zero",
                     b1.chipselect, b1.write, b1.address, b1.word_data, ftime1);
        end
        rst0 = 1'b0; rst1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_framing();
        frame0("framing", 8'h01, 32'h12345678, 1'b0, 48);
    endtask

    task automatic test_error_path();
        frame0("error", 8'h00, 32'hCAFEF00D, 1'b0, 8);
    endtask

    task automatic test_backpressure();
        frame0("backpressure", 8'hFF, 32'h0BADBEEF, 1'b1, 58);
    endtask

    task automatic test_read_latency();
        int cyc;
        valid1 = 8'h01; time1 = 32'h89ABCDEF;
        rd_cyc1 = 0; words1 = 0;
        push_words(1'b1);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        cyc = 1;
        while (done1 !== 1'b1 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (cyc !== 85) begin
            n_fail++;
            $display("FAIL rl1_cycles: got %0d want 85 (done=%b)", cyc, done1);
        end
        n_checks++;
        if (rd_cyc1 !== 74 || words1 !== 8 || exp_q1.size() != 0) begin
            n_fail++;
            $display("FAIL rl1_reads: got reads %0d words %0d left %0d want 74 8 0",
                     rd_cyc1, words1, exp_q1.size());
        end
        n_checks++;
        if (ftime1 !== 32'h89ABCDEF || ferr1 !== 1'b0) begin
            n_fail++;
            $display("FAIL rl1_status: got time %h err %b want 89abcdef 0", ftime1, ferr1);
        end
    endtask

    task automatic test_reset_mid_frame();
        int cyc;
        valid0 = 8'h01; time0 = 32'h5A5AA5A5; words0 = 0;
        push_words(1'b0);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        cyc = 1;
        while (!(b0.chipselect === 1'b1 && b0.write === 1'b0 && b0.address === 16'd17) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (cyc >= 200 || words0 !== 4) begin
            n_fail++;
            $display("FAIL mid_frame_reach: got cycles %0d words %0d want <200 and 4", cyc, words0);
        end
        rst0 = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({busy0, done0, b0.chipselect, b0.write, b0.writedata, b0.address, b0.word_valid,
             b0.word_data, b0.word_index, ftime0, ferr0} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_state: got busy %b cs %b addr %h data %h idx %0d time %h want all zero",
                     busy0, b0.chipselect, b0.address, b0.word_data, b0.word_index, ftime0);
        end
        rst0 = 1'b0;
        exp_q0.delete();
        exp_time0 = 32'h0;
        @(posedge clk); #1;
        frame0("after_reset", 8'h01, 32'h13579BDF, 1'b0, 48);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        start0 = 1'b0; start1 = 1'b0; ready0 = 1'b1;
        valid0 = 8'h01; valid1 = 8'h01; time0 = '0; time1 = '0; exp_time0 = '0;
        rd_cyc0 = 0; rd_cyc1 = 0; words0 = 0; words1 = 0; done_cnt0 = 0; hold0 = 1'b0;
        test_reset();
        test_framing();
        test_error_path();
        test_backpressure();
        test_read_latency();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
